// File: rtl/logic_monostable_pkg.sv
// Shared definitions for the clocked multi-channel monostable.
// Holds the retrigger mode encoding, the packed per-channel input tuple with
// its idle value, and the trigger-condition function used by every channel.
package logic_monostable_pkg;

  typedef enum logic {
    MODE_NONRETRIG = 1'b0,
    MODE_RETRIG    = 1'b1
  } mode_e;

  // One channel's three control pins as sampled in the clock domain.
  typedef struct packed {
    logic na;
    logic b;
    logic nr;
  } pins_t;

  // Inactive pin levels: nA high, B low, nR high.
  localparam pins_t PINS_IDLE = '{na: 1'b1, b: 1'b0, nr: 1'b1};

  // Trigger from the current synchronised sample s and the previous sample p.
  // clr_trig enables the 123-style trigger on a rising nR edge.
  function automatic logic trig_cond(input pins_t s, input pins_t p, input logic clr_trig);
    logic fall_a;
    logic rise_b;
    logic rise_r;
    fall_a = p.na & ~s.na & s.b;
    rise_b = ~p.b & s.b & ~s.na;
    rise_r = clr_trig & ~p.nr & s.nr & ~s.na & s.b;
    return s.nr & (fall_a | rise_b | rise_r);
  endfunction

endpackage

// File: rtl/logic_monostable_ch.sv
// One monostable channel: input synchroniser, edge detection, pulse counter.
// Ports:
//   CLK, nRESET      clock and asynchronous active-low reset
//   nA, B, nR        raw trigger / clear pins for this channel
//   PW [CW-1:0]      pulse width in clock cycles, captured on an accepted trigger
//   Q, nQ            pulse output and its complement
//   TRIG             one-cycle strobe, high in the cycle Q is (re)loaded
module logic_monostable_ch
  import logic_monostable_pkg::*;
#(
  parameter int unsigned CW          = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RETRIG      = 0,
  parameter int unsigned CLR_TRIG    = 0
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          nA,
  input  logic          B,
  input  logic          nR,
  input  logic [CW-1:0] PW,
  output logic          Q,
  output logic          nQ,
  output logic          TRIG
);

  localparam mode_e      MODE = (RETRIG != 0) ? MODE_RETRIG : MODE_NONRETRIG;
  localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);

  pins_t         raw;
  pins_t         s;
  pins_t         p;
  logic [2:0]    warm_cnt;
  logic          armed;
  logic          trig_r;
  logic          clr_r;
  logic          accept;
  logic [CW-1:0] cnt;

  assign raw = '{na: nA, b: B, nr: nR};

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = raw;
  end else begin : g_sync
    pins_t sync_q [SYNC_STAGES];

    always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
        for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PINS_IDLE;
      end else begin
        sync_q[0] <= raw;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // Edges are ignored until the previous-sample register holds a real
  // post-reset sample, so pins held active through reset release do not
  // look like fresh edges against the idle reset values.
  assign armed = (warm_cnt == WARM);

  // Trigger and clear are registered once before acting on the counter; this
  // sets the input-to-Q latency to SYNC_STAGES+1 edges for both.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      warm_cnt <= '0;
      p        <= PINS_IDLE;
      trig_r   <= 1'b0;
      clr_r    <= 1'b0;
    end else begin
      if (!armed) warm_cnt <= warm_cnt + 3'd1;
      p      <= s;
      trig_r <= armed & trig_cond(s, p, (CLR_TRIG != 0));
      clr_r  <= ~s.nr;
    end
  end

  // A trigger landing on the final count (cnt == 1) reloads seamlessly.
  always_comb begin
    accept = 1'b0;
    if (trig_r && !clr_r && (PW != '0)) begin
      accept = (MODE == MODE_RETRIG) || (cnt <= CW'(1));
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      cnt  <= '0;
      TRIG <= 1'b0;
    end else begin
      TRIG <= accept;
      if (clr_r)            cnt <= '0;
      else if (accept)      cnt <= PW;
      else if (cnt != '0)   cnt <= cnt - CW'(1);
    end
  end

  assign Q  = (cnt != '0);
  assign nQ = ~Q;

endmodule

// File: rtl/logic_monostable_multi.sv
// CH independent clocked one-shots with 74HC221/74HC123 trigger semantics.
// Ports:
//   CLK, nRESET        clock and asynchronous active-low reset
//   nA [CH-1:0]        falling-edge triggers (active low)
//   B  [CH-1:0]        rising-edge triggers
//   nR [CH-1:0]        active-low clears
//   PW [CH*CW-1:0]     per-channel pulse width, channel i at [i*CW +: CW]
//   Q, nQ [CH-1:0]     pulse outputs and complements
//   TRIG [CH-1:0]      one-cycle accepted-trigger strobes
module logic_monostable_multi
  import logic_monostable_pkg::*;
#(
  parameter int unsigned CH          = 2,
  parameter int unsigned CW          = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RETRIG      = 0,
  parameter int unsigned CLR_TRIG    = 0
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic [CH-1:0]    nA,
  input  logic [CH-1:0]    B,
  input  logic [CH-1:0]    nR,
  input  logic [CH*CW-1:0] PW,
  output logic [CH-1:0]    Q,
  output logic [CH-1:0]    nQ,
  output logic [CH-1:0]    TRIG
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic_monostable_ch #(
      .CW          (CW),
      .SYNC_STAGES (SYNC_STAGES),
      .RETRIG      (RETRIG),
      .CLR_TRIG    (CLR_TRIG)
    ) u_ch (
      .CLK    (CLK),
      .nRESET (nRESET),
      .nA     (nA[i]),
      .B      (B[i]),
      .nR     (nR[i]),
      .PW     (PW[i*CW +: CW]),
      .Q      (Q[i]),
      .nQ     (nQ[i]),
      .TRIG   (TRIG[i])
    );
  end

endmodule

// File: tb/tb_logic_monostable_multi.sv
// Scoreboard bench for logic_monostable_multi. Three configurations run side
// by side; a reference model tracks each pulse as an absolute end time and
// pushes the expected Q/TRIG per edge, a monitor pops and compares them.
module tb_logic_monostable_multi;

  localparam int NI = 3;
  localparam int S_OF   [NI] = '{2, 1, 0};
  localparam int RT_OF  [NI] = '{0, 1, 0};
  localparam int CT_OF  [NI] = '{0, 1, 1};
  localparam int CW_OF  [NI] = '{16, 16, 4};
  localparam int NCH_OF [NI] = '{2, 2, 1};

  typedef struct {
    logic [1:0] q;
    logic [1:0] trig;
  } exp_t;

  logic CLK;
  logic nRESET;
  logic na_d [NI][2];
  logic b_d  [NI][2];
  logic nr_d [NI][2];
  logic [15:0] pw_d [NI][2];

  logic [1:0]  a_na, a_b, a_nr, a_q, a_nq, a_trig;
  logic [31:0] a_pw;
  logic [1:0]  b_na, b_b, b_nr, b_q, b_nq, b_trig;
  logic [31:0] b_pw;
  logic        c_na, c_b, c_nr, c_q, c_nq, c_trig;
  logic [3:0]  c_pw;

  logic [1:0] q_o  [NI];
  logic [1:0] nq_o [NI];
  logic [1:0] tr_o [NI];

  exp_t       exp_q [NI][$];
  logic [2:0] hq [NI][2][$];
  longint     t_end [NI][2];
  longint     m_cyc;
  bit         chk_en;
  int         n_vec;
  int         n_err;

  assign a_na = {na_d[0][1], na_d[0][0]};
  assign a_b  = {b_d[0][1],  b_d[0][0]};
  assign a_nr = {nr_d[0][1], nr_d[0][0]};
  assign a_pw = {pw_d[0][1], pw_d[0][0]};
  assign b_na = {na_d[1][1], na_d[1][0]};
  assign b_b  = {b_d[1][1],  b_d[1][0]};
  assign b_nr = {nr_d[1][1], nr_d[1][0]};
  assign b_pw = {pw_d[1][1], pw_d[1][0]};
  assign c_na = na_d[2][0];
  assign c_b  = b_d[2][0];
  assign c_nr = nr_d[2][0];
  assign c_pw = pw_d[2][0][3:0];

  assign q_o[0]  = a_q;
  assign nq_o[0] = a_nq;
  assign tr_o[0] = a_trig;
  assign q_o[1]  = b_q;
  assign nq_o[1] = b_nq;
  assign tr_o[1] = b_trig;
  assign q_o[2]  = {1'b0, c_q};
  assign nq_o[2] = {1'b1, c_nq};
  assign tr_o[2] = {1'b0, c_trig};

  logic_monostable_multi #(
    .CH(2), .CW(16), .SYNC_STAGES(2), .RETRIG(0), .CLR_TRIG(0)
  ) u_a (
    .CLK(CLK), .nRESET(nRESET), .nA(a_na), .B(a_b), .nR(a_nr), .PW(a_pw),
    .Q(a_q), .nQ(a_nq), .TRIG(a_trig)
  );

  logic_monostable_multi #(
    .CH(2), .CW(16), .SYNC_STAGES(1), .RETRIG(1), .CLR_TRIG(1)
  ) u_b (
    .CLK(CLK), .nRESET(nRESET), .nA(b_na), .B(b_b), .nR(b_nr), .PW(b_pw),
    .Q(b_q), .nQ(b_nq), .TRIG(b_trig)
  );

  logic_monostable_multi #(
    .CH(1), .CW(4), .SYNC_STAGES(0), .RETRIG(0), .CLR_TRIG(1)
  ) u_c (
    .CLK(CLK), .nRESET(nRESET), .nA(c_na), .B(c_b), .nR(c_nr), .PW(c_pw),
    .Q(c_q), .nQ(c_nq), .TRIG(c_trig)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Trigger rules on {nA, B, nR} tuples: prv is the older sample, cur the newer.
  function automatic bit ev(logic [2:0] prv, logic [2:0] cur, bit ct);
    bit fall_a, rise_b, rise_r;
    fall_a = prv[2] && !cur[2] && cur[1];
    rise_b = !prv[1] && cur[1] && !cur[2];
    rise_r = ct && !prv[0] && cur[0] && !cur[2] && cur[1];
    return cur[0] && (fall_a || rise_b || rise_r);
  endfunction

  // Expected outputs after edge m_cyc. An input sampled at edge k takes effect
  // at edge k+S+1; a pulse loaded at edge m lasts while edge index < m+PW.
  task automatic model_edge();
    m_cyc++;
    for (int i = 0; i < NI; i++) begin
      exp_t e;
      e.q = '0;
      e.trig = '0;
      for (int c = 0; c < NCH_OF[i]; c++) begin
        logic [2:0] cur, prv;
        bit cur_ok, prv_ok;
        int len, s;
        longint pwv;
        hq[i][c].push_back({na_d[i][c], b_d[i][c], nr_d[i][c]});
        if (hq[i][c].size() > 5) void'(hq[i][c].pop_front());
        len = hq[i][c].size();
        s = S_OF[i];
        cur_ok = (s + 1 < len);
        prv_ok = (s + 2 < len);
        cur = cur_ok ? hq[i][c][len-2-s] : 3'b101;
        prv = prv_ok ? hq[i][c][len-3-s] : 3'b101;
        pwv = longint'(pw_d[i][c]) & ((64'd1 << CW_OF[i]) - 64'd1);
        if (cur_ok && !cur[0]) begin
          t_end[i][c] = m_cyc;
        end else if (prv_ok && ev(prv, cur, CT_OF[i] != 0) && pwv != 0 &&
                     (RT_OF[i] != 0 || m_cyc >= t_end[i][c])) begin
          t_end[i][c] = m_cyc + pwv;
          e.trig[c] = 1'b1;
        end
        e.q[c] = (m_cyc < t_end[i][c]);
      end
      exp_q[i].push_back(e);
    end
  endtask

  task automatic chk(string nm, int i, int c, logic got, logic want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s inst%0d ch%0d t=%0t got=%b expected=%b", nm, i, c, $time, got, want);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        if (exp_q[i].size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard_empty inst%0d t=%0t got=0 entries expected=1", i, $time);
        end else begin
          exp_t e;
          e = exp_q[i].pop_front();
          for (int c = 0; c < NCH_OF[i]; c++) begin
            chk("Q", i, c, q_o[i][c], e.q[c]);
            chk("nQ", i, c, nq_o[i][c], ~e.q[c]);
            chk("TRIG", i, c, tr_o[i][c], e.trig[c]);
          end
        end
      end
    end
  end

  task automatic cycle();
    model_edge();
    @(posedge CLK);
    #2;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic pins(int i, int c, logic na, logic b, logic nr);
    na_d[i][c] = na;
    b_d[i][c]  = b;
    nr_d[i][c] = nr;
  endtask

  task automatic model_reset();
    m_cyc = 0;
    for (int i = 0; i < NI; i++) begin
      exp_q[i].delete();
      for (int c = 0; c < 2; c++) begin
        hq[i][c].delete();
        t_end[i][c] = 0;
      end
    end
  endtask

  task automatic rand_step();
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < NCH_OF[i]; c++) begin
        if ($urandom_range(3) == 0) na_d[i][c] = ~na_d[i][c];
        if ($urandom_range(3) == 0) b_d[i][c] = ~b_d[i][c];
        if (nr_d[i][c] && $urandom_range(39) == 0) nr_d[i][c] = 1'b0;
        else if (!nr_d[i][c] && $urandom_range(3) == 0) nr_d[i][c] = 1'b1;
        if ($urandom_range(15) == 0)
          pw_d[i][c] = ($urandom_range(7) == 0) ? 16'd0 : 16'($urandom_range(25, 1));
      end
    end
    cycle();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    chk_en = 1'b0;
    nRESET = 1'b0;
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < 2; c++) begin
        pins(i, c, 1'b1, 1'b0, 1'b1);
        pw_d[i][c] = 16'd0;
      end
    end
    model_reset();
    repeat (3) @(negedge CLK);
    #1;
    nRESET = 1'b1;
    chk_en = 1'b1;
    run(6);

    // Basic 221 trigger on A ch0, PW=5.
    pw_d[0][0] = 16'd5;
    pins(0, 0, 1'b1, 1'b1, 1'b1); run(2);
    pins(0, 0, 1'b0, 1'b1, 1'b1); run(12);

    // Non-retriggerable: second fall 4 cycles later, then one on the final count.
    pw_d[0][0] = 16'd10;
    pins(0, 0, 1'b1, 1'b1, 1'b1); run(2);
    pins(0, 0, 1'b0, 1'b1, 1'b1); run(1);
    pins(0, 0, 1'b1, 1'b1, 1'b1); run(3);
    pins(0, 0, 1'b0, 1'b1, 1'b1); run(1);
    pins(0, 0, 1'b1, 1'b1, 1'b1); run(15);
    pins(0, 0, 1'b0, 1'b1, 1'b1); run(1);
    pins(0, 0, 1'b1, 1'b1, 1'b1); run(9);
    pins(0, 0, 1'b0, 1'b1, 1'b1); run(1);
    pins(0, 0, 1'b1, 1'b0, 1'b1); run(25);

    // Retriggerable on B ch0: falls 6 cycles apart, PW=10.
    pw_d[1][0] = 16'd10;
    pins(1, 0, 1'b1, 1'b1, 1'b1); run(2);
    pins(1, 0, 1'b0, 1'b1, 1'b1); run(1);
    pins(1, 0, 1'b1, 1'b1, 1'b1); run(5);
    pins(1, 0, 1'b0, 1'b1, 1'b1); run(1);
    pins(1, 0, 1'b1, 1'b0, 1'b1); run(20);

    // Clear mid-pulse on A ch1 (no clear-trigger) and B ch1 (clear-trigger).
    for (int i = 0; i < 2; i++) begin
      pw_d[i][1] = 16'd100;
      pins(i, 1, 1'b1, 1'b1, 1'b1);
    end
    run(2);
    for (int i = 0; i < 2; i++) pins(i, 1, 1'b0, 1'b1, 1'b1);
    run(24);
    for (int i = 0; i < 2; i++) pins(i, 1, 1'b0, 1'b1, 1'b0);
    run(6);
    for (int i = 0; i < 2; i++) pins(i, 1, 1'b0, 1'b0, 1'b0);
    run(2);
    for (int i = 0; i < 2; i++) pins(i, 1, 1'b0, 1'b1, 1'b0);
    run(3);
    for (int i = 0; i < 2; i++) pins(i, 1, 1'b0, 1'b1, 1'b1);
    run(110);
    for (int i = 0; i < 2; i++) pins(i, 1, 1'b1, 1'b0, 1'b1);
    run(3);

    // C: PW=0 ignored, then maximum 4-bit width.
    pw_d[2][0] = 16'd0;
    pins(2, 0, 1'b1, 1'b1, 1'b1); run(2);
    pins(2, 0, 1'b0, 1'b1, 1'b1); run(5);
    pw_d[2][0] = 16'd15;
    pins(2, 0, 1'b1, 1'b1, 1'b1); run(2);
    pins(2, 0, 1'b0, 1'b1, 1'b1); run(20);
    pins(2, 0, 1'b1, 1'b0, 1'b1); run(2);

    // A ch1: full 16-bit width, PW changed mid-pulse.
    pw_d[0][1] = 16'hFFFF;
    pins(0, 1, 1'b1, 1'b1, 1'b1); run(2);
    pins(0, 1, 1'b0, 1'b1, 1'b1); run(10);
    pw_d[0][1] = 16'd3;
    run(65540);
    pins(0, 1, 1'b1, 1'b0, 1'b1); run(2);

    // Asynchronous reset mid-pulse on A ch0.
    pw_d[0][0] = 16'd50;
    pins(0, 0, 1'b1, 1'b1, 1'b1); run(2);
    pins(0, 0, 1'b0, 1'b1, 1'b1); run(20);
    @(negedge CLK);
    #1;
    chk_en = 1'b0;
    nRESET = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < NCH_OF[i]; c++) begin
        chk("reset_Q", i, c, q_o[i][c], 1'b0);
        chk("reset_nQ", i, c, nq_o[i][c], 1'b1);
        chk("reset_TRIG", i, c, tr_o[i][c], 1'b0);
      end
    end
    for (int i = 0; i < NI; i++) begin
      for (int c = 0; c < NCH_OF[i]; c++) begin
        pins(i, c, 1'b0, 1'b1, 1'b1);
        pw_d[i][c] = 16'd7;
      end
    end
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    nRESET = 1'b1;
    chk_en = 1'b1;
    run(20);
    for (int c = 0; c < 2; c++) pins(0, c, 1'b1, 1'b1, 1'b1);
    run(2);
    for (int c = 0; c < 2; c++) pins(0, c, 1'b0, 1'b1, 1'b1);
    run(12);

    // Randomised traffic on all channels.
    repeat (3000) rand_step();

    @(negedge CLK);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
